uart_mmio_ctrl: RTL and testbench
=================================

// Module: uart_mmio_ctrl
// PURPOSE
//  Memory-mapped controller between the Riscv150 data-memory port and the UART byte interface.
//  - Decodes CPU loads/stores in the IO region.
//  - Buffers outgoing bytes in a TX FIFO and holds one received byte.
//  - Drives the UART ready/valid handshakes so software polls status and never touches UART timing.
// PARAMETERS
//  BASE_ADDR   32'h8000_0000  IO region base; decode uses addr[31:28]==BASE_ADDR[31:28] and addr[4:2]
//  TX_DEPTH    8              TX FIFO entries; power of 2, >=2
// PORTS
//  clk        in   1   system clock, all state on posedge
//  rst        in   1   synchronous, active-high reset
//  stall      in   1   CPU pipeline stall; while 1, re/we are ignored and rdata holds
//  addr       in   32  byte address of CPU access
//  re         in   1   load strobe, one cycle per access
//  we         in   1   store strobe, one cycle per access
//  wdata      in   32  store data
//  rdata      out  32  load data, registered, valid cycle after re
//  tx_data    out  8   byte to UART transmitter (FIFO head)
//  tx_valid   out  1   FIFO non-empty
//  tx_ready   in   1   UART accepts tx_data this cycle
//  rx_data    in   8   byte from UART receiver
//  rx_valid   in   1   rx_data valid
//  rx_ready   out  1   controller can take a byte (holding register empty or being read)
// BEHAVIOUR
//  Reset values: rdata=0, tx_valid=0, rx_ready=1; FIFO count 0, rx_avail=0, tx_ovf=0.
//  Map, word offset addr[4:2]:
//   0 STATUS  R {29'b0, tx_ovf, rx_avail, tx_space}. tx_space = count<TX_DEPTH. A read clears tx_ovf.
//   1 RXDATA  R {24'b0, rx_byte}. A read with rx_avail=1 clears rx_avail. With rx_avail=0: returns 0, no side effect.
//   2 TXDATA  W push wdata[7:0]; upper bits ignored.
//   others    R 0; W ignored (except offsets in CONFIGURATION).
//  re and we both high: the write is performed and rdata is loaded per the read address.
//  Load latency exactly 1 cycle. rdata holds its last value when no read occurs.
//  TX FIFO:
//   - pop on tx_valid&tx_ready.
//   - push accepted iff count<TX_DEPTH, or a pop occurs the same cycle.
//   - A push while full with no pop is dropped and sets tx_ovf.
//   - Simultaneous push+pop: count unchanged, data order preserved.
//   - Pointers wrap modulo TX_DEPTH.
//   - tx_data is stable while tx_valid=1 and tx_ready=0.
//  RX:
//   - rx_ready = ~rx_avail | (RXDATA read this cycle).
//   - Capture when rx_valid&rx_ready.
//   - Capture in the same cycle as a read: the old byte goes to rdata, the new byte is stored, rx_avail stays 1.
//  rst mid-transfer: FIFO contents and the RX byte are discarded. tx_valid drops the next cycle, even if a UART byte is in flight.
// CONFIGURATION
//  UART_CYCLE_COUNTER_EN defined:
//   - 32-bit free-running cycle counter, +1 every cycle (including stall), wraps at 2^32.
//   - Offset 4 R: counter value.
//   - Offset 6 W: any store clears the counter. On the next cycle the counter reads 1.
//   - A clear and an increment in the same cycle: the clear wins.
//  Undefined: no counter logic. Offsets 4 and 6 behave as unmapped (R 0, W ignored).
// STRUCTURE
//  Shared include riscv_mmio_defs.vh holds:
//   - IO region nibble.
//   - Offset constants OFS_STATUS/OFS_RXDATA/OFS_TXDATA/OFS_CYCLE/OFS_CYCLE_RST.
//   - STATUS bit indices.
//   The CPU decoder and software headers use the same file.
//  Sub-module: uart_tx_fifo (sync FIFO, DEPTH param, push/pop/full/empty/count). Everything else is inline.
// TESTING
//  1 Reset: assert rst 2 cycles -> rdata=0, tx_valid=0, rx_ready=1. STATUS read returns 32'h1.
//  2 TX order: tx_ready=0; store 'A','B','C' to 0x80000008; then tx_ready=1
//    -> tx_data 0x41,0x42,0x43 in order; tx_valid=0 after the third pop.
//  3 Overflow: tx_ready=0; 9 stores at TX_DEPTH=8 -> 9th dropped; STATUS=32'h4 (tx_space=0, tx_ovf=1);
//    next STATUS read returns 32'h0.
//  4 RX race: rx byte 0x55 captured, then read RXDATA while rx_valid=1 with 0xAA in the same cycle
//    -> rdata=0x55; STATUS returns 32'h3; next RXDATA=0xAA.
//  5 Stall: stall=1 during a TXDATA store and an RXDATA read -> FIFO count unchanged, rx_avail unchanged, rdata holds.
//  6 Counter (macro on): store to offset 6, wait 10 cycles, read offset 4 -> 10 (+1 per cycle of read latency, checked exactly).
//    Macro off: read offset 4 -> 0.

Source files
------------

// File: rtl/uart_mmio_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// uart_mmio_ctrl_pkg
// Shared definitions for the UART memory-mapped controller: the IO region
// nibble, the register word offsets (addr[4:2]) and the STATUS bit indices.
// The CPU address decoder and the software headers use the same values.
// ---------------------------------------------------------------------------
package uart_mmio_ctrl_pkg;

  // Upper address nibble that selects the IO region.
  localparam logic [3:0] IO_REGION_NIBBLE = 4'h8;

  // Word offsets within the IO region, taken from addr[4:2].
  typedef enum logic [2:0] {
    OFS_STATUS    = 3'd0,
    OFS_RXDATA    = 3'd1,
    OFS_TXDATA    = 3'd2,
    OFS_CYCLE     = 3'd4,
    OFS_CYCLE_RST = 3'd6
  } mmioOfs_e;

  // STATUS register bit positions.
  localparam int STAT_TX_SPACE = 0;
  localparam int STAT_RX_AVAIL = 1;
  localparam int STAT_TX_OVF   = 2;

  // True when the address falls inside the region selected by baseAddr.
  function automatic logic isIoRegion(input logic [31:0] addr,
                                      input logic [31:0] baseAddr);
    return addr[31:28] == baseAddr[31:28];
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
// Synchronous FIFO holding bytes waiting for the UART transmitter.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   push, pushData    write request and data
//   pop               read request (ignored while empty)
//   popData           head of the FIFO
//   full, empty       occupancy flags
//   count             number of stored entries (0..DEPTH)
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           pushData,
  input  logic                       pop,
  output logic [WIDTH-1:0]           popData,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [AW:0]      r_count;
  logic             w_doPop;
  logic             w_doPush;

  assign empty   = (r_count == '0);
  assign full    = (r_count == (AW+1)'(DEPTH));
  assign count   = r_count;
  assign popData = r_mem[r_rdPtr];

  // A push into a full FIFO is still accepted when the head leaves this cycle.
  assign w_doPop  = pop & ~empty;
  assign w_doPush = push & (~full | w_doPop);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + AW'(1);
      if (w_doPop)  r_rdPtr <= r_rdPtr + AW'(1);
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents are don't-care after reset since count is 0.
  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wrPtr] <= pushData;
  end

endmodule

// File: rtl/uart_mmio_ctrl.sv
// ---------------------------------------------------------------------------
// uart_mmio_ctrl
// Memory-mapped bridge between the CPU data-memory port and the UART byte
// interface. Outgoing bytes are buffered in a TX FIFO, one received byte is
// held in a register, and software polls STATUS.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   stall                 CPU stall; accesses ignored, rdata holds
//   addr, re, we, wdata   CPU load/store port
//   rdata                 registered load data (valid the cycle after re)
//   tx_data, tx_valid     FIFO head toward the UART transmitter
//   tx_ready              transmitter accepts tx_data
//   rx_data, rx_valid     byte from the UART receiver
//   rx_ready              holding register can take a byte
// Optional feature: define UART_CYCLE_COUNTER_EN for a free-running cycle
// counter readable at offset 4 and cleared by any store to offset 6.
// ---------------------------------------------------------------------------
module uart_mmio_ctrl
  import uart_mmio_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          TX_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [31:0] addr,
  input  logic        re,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  localparam int CW = $clog2(TX_DEPTH) + 1;

  logic [31:0]   r_rdata;
  logic          r_txOvf;
  logic          r_rxAvail;
  logic [7:0]    r_rxByte;

  logic          w_sel;
  logic          w_rd;
  logic          w_wr;
  logic [2:0]    w_ofs;
  logic          w_txPush;
  logic          w_txPop;
  logic          w_fifoFull;
  logic          w_fifoEmpty;
  logic [CW-1:0] w_fifoCount;
  logic          w_txSpace;
  logic          w_statusRead;
  logic          w_rxRead;
  logic          w_rxCapture;
  logic [31:0]   w_rdValue;
  logic          w_unused;

  // Address bits outside the decode and upper store bits are not used.
  assign w_unused = ^{addr[27:5], addr[1:0], wdata[31:8]};

  assign w_sel = isIoRegion(addr, BASE_ADDR);
  assign w_ofs = addr[4:2];
  assign w_rd  = re & ~stall & w_sel;
  assign w_wr  = we & ~stall & w_sel;

  assign w_txPush     = w_wr & (w_ofs == OFS_TXDATA);
  assign w_txPop      = tx_valid & tx_ready;
  assign w_txSpace    = (w_fifoCount < CW'(TX_DEPTH));
  assign w_statusRead = w_rd & (w_ofs == OFS_STATUS);
  assign w_rxRead     = w_rd & (w_ofs == OFS_RXDATA) & r_rxAvail;

  // The holding register frees up in the same cycle it is being read.
  assign rx_ready    = ~r_rxAvail | w_rxRead;
  assign w_rxCapture = rx_valid & rx_ready;

  assign tx_valid = ~w_fifoEmpty;
  assign rdata    = r_rdata;

  uart_tx_fifo #(
    .DEPTH (TX_DEPTH),
    .WIDTH (8)
  ) u_txFifo (
    .clk      (clk),
    .rst      (rst),
    .push     (w_txPush),
    .pushData (wdata[7:0]),
    .pop      (w_txPop),
    .popData  (tx_data),
    .full     (w_fifoFull),
    .empty    (w_fifoEmpty),
    .count    (w_fifoCount)
  );

`ifdef UART_CYCLE_COUNTER_EN
  logic [31:0] r_cycle;
  logic        w_cycleClear;

  assign w_cycleClear = w_wr & (w_ofs == OFS_CYCLE_RST);

  // Free-running counter; runs through stalls and a clear beats the increment.
  always_ff @(posedge clk) begin
    if (rst || w_cycleClear) r_cycle <= '0;
    else                     r_cycle <= r_cycle + 32'd1;
  end
`endif

  // Load data mux. The cycle counter is reported as the value it holds when
  // rdata becomes visible, so a read right after a clear returns 1.
  always_comb begin
    w_rdValue = '0;
    case (w_ofs)
      OFS_STATUS: begin
        w_rdValue[STAT_TX_SPACE] = w_txSpace;
        w_rdValue[STAT_RX_AVAIL] = r_rxAvail;
        w_rdValue[STAT_TX_OVF]   = r_txOvf;
      end
      OFS_RXDATA: if (r_rxAvail) w_rdValue = {24'b0, r_rxByte};
`ifdef UART_CYCLE_COUNTER_EN
      OFS_CYCLE:  w_rdValue = r_cycle + 32'd1;
`endif
      default:    w_rdValue = '0;
    endcase
  end

  // Registered load data; holds when no read is accepted.
  always_ff @(posedge clk) begin
    if (rst)       r_rdata <= '0;
    else if (w_rd) r_rdata <= w_rdValue;
  end

  // Sticky overflow flag; a new overflow in the clearing cycle is kept.
  always_ff @(posedge clk) begin
    if (rst)                                     r_txOvf <= 1'b0;
    else if (w_txPush && w_fifoFull && !w_txPop) r_txOvf <= 1'b1;
    else if (w_statusRead)                       r_txOvf <= 1'b0;
  end

  // RX holding register; a capture during a read keeps rx_avail set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rxAvail <= 1'b0;
      r_rxByte  <= '0;
    end else if (w_rxCapture) begin
      r_rxAvail <= 1'b1;
      r_rxByte  <= rx_data;
    end else if (w_rxRead) begin
      r_rxAvail <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_mmio_ctrl
// Directed bench for uart_mmio_ctrl with hand-computed expected values.
// Honours UART_CYCLE_COUNTER_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_uart_mmio_ctrl;

  localparam logic [31:0] A_STATUS = 32'h8000_0000;
  localparam logic [31:0] A_RXDATA = 32'h8000_0004;
  localparam logic [31:0] A_TXDATA = 32'h8000_0008;
  localparam logic [31:0] A_CYCLE  = 32'h8000_0010;
  localparam logic [31:0] A_CYCRST = 32'h8000_0018;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [31:0] addr;
  logic        re;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;

  int vecCount  = 0;
  int missCount = 0;

  uart_mmio_ctrl #(
    .BASE_ADDR (32'h8000_0000),
    .TX_DEPTH  (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .stall    (stall),
    .addr     (addr),
    .re       (re),
    .we       (we),
    .wdata    (wdata),
    .rdata    (rdata),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one CPU access for exactly one cycle.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d,
                               input logic doRe, input logic doWe);
    addr  = a;
    wdata = d;
    re    = doRe;
    we    = doWe;
    tick();
    re = 1'b0;
    we = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic readCheck(input string tag, input logic [31:0] a,
                           input logic [31:0] expected);
    applyStimulus(a, 32'h0, 1'b1, 1'b0);
    checkOutput(tag, rdata, expected);
  endtask

  task automatic rxPulse(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] expQ [$];
    rst = 1'b1; stall = 1'b0; addr = '0; re = 1'b0; we = 1'b0; wdata = '0;
    tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;

    // Reset state
    tick(); tick();
    checkOutput("rst_rdata", rdata, 32'h0);
    checkOutput("rst_txvalid", 32'(tx_valid), 32'h0);
    checkOutput("rst_rxready", 32'(rx_ready), 32'h1);
    rst = 1'b0;
    readCheck("rst_status", A_STATUS, 32'h1);

    // TX ordering
    applyStimulus(A_TXDATA, 32'hFFFF_FF41, 1'b0, 1'b1);
    applyStimulus(A_TXDATA, 32'h0000_0042, 1'b0, 1'b1);
    applyStimulus(A_TXDATA, 32'h1234_5643, 1'b0, 1'b1);
    checkOutput("tx_valid_held", 32'(tx_valid), 32'h1);
    checkOutput("tx_head_held", 32'(tx_data), 32'h41);
    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("tx_order%0d", i), 32'(tx_data), 32'h41 + i);
      tick();
    end
    checkOutput("tx_drained", 32'(tx_valid), 32'h0);
    tx_ready = 1'b0;

    // Overflow, then a push into a full FIFO alongside a pop
    for (int i = 0; i < 9; i++) applyStimulus(A_TXDATA, 32'h10 + i, 1'b0, 1'b1);
    readCheck("ovf_status", A_STATUS, 32'h4);
    readCheck("ovf_cleared", A_STATUS, 32'h0);
    tx_ready = 1'b1;
    applyStimulus(A_TXDATA, 32'h99, 1'b0, 1'b1);
    tx_ready = 1'b0;
    readCheck("full_pushpop", A_STATUS, 32'h0);
    for (int i = 1; i < 8; i++) expQ.push_back(8'(8'h10 + i));
    expQ.push_back(8'h99);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("ovf_drain%0d", i), 32'(tx_data), 32'(expQ[i]));
      tick();
    end
    checkOutput("ovf_empty", 32'(tx_valid), 32'h0);
    tx_ready = 1'b0;

    // RX capture racing a read
    rxPulse(8'h55);
    checkOutput("rx_full_notready", 32'(rx_ready), 32'h0);
    addr = A_RXDATA; re = 1'b1; rx_data = 8'hAA; rx_valid = 1'b1;
    #1;
    checkOutput("rx_ready_on_read", 32'(rx_ready), 32'h1);
    tick();
    re = 1'b0; rx_valid = 1'b0;
    checkOutput("rx_race_old", rdata, 32'h55);
    readCheck("rx_race_status", A_STATUS, 32'h3);
    readCheck("rx_race_new", A_RXDATA, 32'hAA);
    readCheck("rx_empty_read", A_RXDATA, 32'h0);
    rxPulse(8'h11);
    rxPulse(8'h22);
    readCheck("rx_no_overwrite", A_RXDATA, 32'h11);

    // Stall suppresses accesses
    rxPulse(8'h66);
    stall = 1'b1;
    applyStimulus(A_TXDATA, 32'h77, 1'b0, 1'b1);
    applyStimulus(A_RXDATA, 32'h0, 1'b1, 1'b0);
    stall = 1'b0;
    checkOutput("stall_rdata_hold", rdata, 32'h11);
    checkOutput("stall_no_push", 32'(tx_valid), 32'h0);
    readCheck("stall_status", A_STATUS, 32'h3);
    readCheck("stall_rx_kept", A_RXDATA, 32'h66);

    // Simultaneous read and write
    applyStimulus(A_TXDATA, 32'h5A, 1'b1, 1'b1);
    checkOutput("rw_rdata", rdata, 32'h0);
    checkOutput("rw_pushed", 32'(tx_data), 32'h5A);

    // Reset with a byte pending
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rst_mid_txvalid", 32'(tx_valid), 32'h0);
    readCheck("rst_mid_status", A_STATUS, 32'h1);

    // Stores outside the region or to unmapped offsets
    applyStimulus(32'h0000_0008, 32'h33, 1'b0, 1'b1);
    applyStimulus(32'h8000_000C, 32'h34, 1'b0, 1'b1);
    checkOutput("unmapped_store", 32'(tx_valid), 32'h0);

`ifdef UART_CYCLE_COUNTER_EN
    applyStimulus(A_CYCRST, 32'h0, 1'b0, 1'b1);
    readCheck("cycle_after_clear", A_CYCLE, 32'h1);
    applyStimulus(A_CYCRST, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) tick();
    readCheck("cycle_10", A_CYCLE, 32'd10);
`else
    applyStimulus(A_CYCRST, 32'hFFFF, 1'b0, 1'b1);
    readCheck("cycle_absent", A_CYCLE, 32'h0);
    readCheck("cycrst_absent", A_CYCRST, 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
